truth_table_sweep_ctrl: RTL and testbench
=========================================

TRUTH_TABLE_SWEEP_CTRL -- requirements
Module: truth_table_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE_W, 8, width of settle-count input.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  sweep request, sampled only in IDLE.
REQ-005 expected  input  8  expected truth table; bit 7-k is the output for row k={in1,in2,in3} (row 000 = MSB).
REQ-006 settle  input  SETTLE_W  per-row settle count, latched at start.
REQ-007 dut_out  input  1  output of gate under test, may be asynchronous.
REQ-008 in1, in2, in3  output  1 each  row vector driven to gate under test.
REQ-009 busy  output  1  high from cycle after accepted start until DONE.
REQ-010 done  output  1  one-cycle pulse at sweep end.
REQ-011 pass  output  1  observed == expected, valid from done, held until next accepted start.
REQ-012 observed  output  8  sampled truth table, same bit order as expected.
REQ-013 mismatch  output  8  observed XOR latched expected, held with pass.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE with start=1: latch expected and settle, clear observed, row index=0, load counter, go to SETTLE.
REQ-016 Effective settle = max(settle, 2), covering the 2-flop dut_out synchronizer.
REQ-017 in1/in2/in3 = row index bits [2:1:0] in SETTLE and SAMPLE; 000 in IDLE and DONE.
REQ-018 SETTLE: counter decrements each cycle; at counter==0, next state SAMPLE; SETTLE lasts effective settle+1 cycles.
REQ-019 SAMPLE (1 cycle): observed[7-index] <= synchronized dut_out; if index==7 go to DONE, else index+1, reload counter, go to SETTLE.
REQ-020 Each row held effective settle+2 cycles; done asserts exactly 8*(effective settle+2)+1 cycles after the start-accept edge.
REQ-021 DONE (1 cycle): done=1, busy=0, pass and mismatch registered; next state IDLE.
REQ-022 start while busy or in DONE is ignored; no queuing.
REQ-023 start high continuously restarts a new sweep in the cycle after DONE.
REQ-024 Counter width SETTLE_W; settle = all-ones has no wrap hazard (counter reloads, never underflows below 0).

Reset
REQ-025 rst_n=0 at a clock edge: state IDLE, index 0, counter 0, in1..in3=0, busy=0, done=0, pass=0, observed=0, mismatch=0, synchronizer flops 0.
REQ-026 Reset mid-sweep aborts with no done pulse; outputs reach reset values on the following edge.
REQ-027 Reset has priority over start in the same cycle.

Configuration
REQ-028 Macro SWEEP_STOP_ON_FAIL_EN.
REQ-029 Defined: extra output fail_idx [2:0] (reset 0); in SAMPLE, if sampled bit differs from expected[7-index], record index in fail_idx and go directly to DONE with pass=0; unsampled observed bits stay 0; mismatch compares only sampled rows (unsampled bits 0).
REQ-030 Undefined: no fail_idx port; full 8-row sweep always runs.

Verification
REQ-031 expected=0x4A, settle=3, ideal 0x4A gate model -> done at 41 cycles after start accept, pass=1, observed=0x4A, mismatch=0x00.
REQ-032 dut_out stuck 0, expected=0x4A, settle=3 -> observed=0x00, mismatch=0x4A, pass=0.
REQ-033 settle=0 -> clamped to 2, done at 33 cycles; settle=1 gives identical timing.
REQ-034 rst_n low at cycle 10 of sweep -> no done, all outputs 0 next edge; subsequent start runs a clean full sweep.
REQ-035 start pulsed during busy -> ignored, single done; model inverting row 3 (expected 0x4A) -> without macro observed=0x5A, mismatch=0x10, pass=0; with SWEEP_STOP_ON_FAIL_EN done after row 3, fail_idx=3, observed=0x50, mismatch=0x10.

Source files
------------

// File: rtl/truth_table_sweep_ctrl.sv
// Truth-table sweep controller: walks the 8 input rows of a 3-input gate, samples its output and compares.
// Optional SWEEP_STOP_ON_FAIL_EN: abort at the first wrong row and report it on fail_idx.
module truth_table_sweep_ctrl #(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          expected,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                dut_out,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          observed,
  output logic [7:0]          mismatch
`ifdef SWEEP_STOP_ON_FAIL_EN
  ,
  output logic [2:0]          fail_idx
`endif
);

  // state  | meaning
  // IDLE   | waiting for start, row vector 000
  // SETTLE | row applied, counting down settle time
  // SAMPLE | capture synchronized gate output for current row
  // DONE   | one-cycle completion pulse, results valid
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state, next_state;
  logic [2:0]          index;
  logic [SETTLE_W-1:0] count;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_eff;
  logic [7:0]          exp_q;
  logic                sync1, sync2;
  logic [7:0]          obs_next;
  logic [7:0]          row_mask;
  logic                last_row;

  // Two cycles minimum so the synchronizer has flushed the previous row.
  assign settle_eff = (settle < SETTLE_W'(2)) ? SETTLE_W'(2) : settle;

  // Rows sampled so far: bits 7 down to 7-index.
  assign row_mask = 8'hFF << (3'd7 - index);

`ifdef SWEEP_STOP_ON_FAIL_EN
  logic row_bad;
  assign row_bad  = (sync2 != exp_q[3'd7 - index]);
  assign last_row = (index == 3'd7) || row_bad;
`else
  assign last_row = (index == 3'd7);
`endif

  always_comb begin
    obs_next = observed;
    obs_next[3'd7 - index] = sync2;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE:  if (count == '0) next_state = SAMPLE;
      SAMPLE:  next_state = last_row ? DONE : SETTLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SETTLE) || (state == SAMPLE);
    done = (state == DONE);
    {in1, in2, in3} = busy ? index : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= 3'd0;
      count    <= '0;
      settle_q <= '0;
      exp_q    <= 8'h00;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      pass     <= 1'b0;
      observed <= 8'h00;
      mismatch <= 8'h00;
`ifdef SWEEP_STOP_ON_FAIL_EN
      fail_idx <= 3'd0;
`endif
    end else begin
      state <= next_state;
      sync1 <= dut_out;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q    <= expected;
            settle_q <= settle_eff;
            count    <= settle_eff;
            index    <= 3'd0;
            observed <= 8'h00;
            pass     <= 1'b0;
            mismatch <= 8'h00;
`ifdef SWEEP_STOP_ON_FAIL_EN
            fail_idx <= 3'd0;
`endif
          end
        end
        SETTLE: begin
          if (count != '0) count <= count - SETTLE_W'(1);
        end
        SAMPLE: begin
          observed <= obs_next;
          if (last_row) begin
            mismatch <= (obs_next ^ exp_q) & row_mask;
            pass     <= (((obs_next ^ exp_q) & row_mask) == 8'h00);
`ifdef SWEEP_STOP_ON_FAIL_EN
            if (row_bad) fail_idx <= index;
`endif
          end else begin
            index <= index + 3'd1;
            count <= settle_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// Directed bench for truth_table_sweep_ctrl with a behavioural 3-input gate model.
// Cycle numbering: cycle 1 is the first clock period after the start-accept edge.
module tb_truth_table_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] expected;
  logic [7:0] settle;
  logic       dut_out;
  logic       in1, in2, in3, busy, done, pass;
  logic [7:0] observed, mismatch;
`ifdef SWEEP_STOP_ON_FAIL_EN
  logic [2:0] fail_idx;
`endif

  logic [7:0] model_tt;
  logic       stuck0, inv3;
  logic [2:0] row;

  int checks = 0;
  int errors = 0;

  int         res_done_cycle, res_done_count;
  logic       res_seq_ok, res_pass;
  logic [7:0] res_obs, res_mm;
  logic [2:0] res_fail;
  int         cyc, ndone;

  always #5 clk = ~clk;

  assign row     = {in1, in2, in3};
  assign dut_out = stuck0 ? 1'b0 : (model_tt[3'd7 - row] ^ (inv3 && row == 3'd3));

  truth_table_sweep_ctrl #(.SETTLE_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
    .settle   (settle),
    .dut_out  (dut_out),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .observed (observed),
    .mismatch (mismatch)
`ifdef SWEEP_STOP_ON_FAIL_EN
    ,
    .fail_idx (fail_idx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a sweep and follow it cycle by cycle; pa/pb are cycles in which start is pulsed again.
  task automatic sweep(input logic [7:0] exp_tt, input logic [7:0] st,
                       input int pa, input int pb, input int tail);
    int eff, rowlen;
    expected = exp_tt;
    settle   = st;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    eff    = (st < 2) ? 2 : int'(st);
    rowlen = eff + 2;
    res_done_cycle = -1;
    res_done_count = 0;
    res_seq_ok     = 1'b1;
    res_fail       = 3'd0;
    for (int c = 1; c <= 8 * rowlen + 1 + tail; c++) begin
      if (done) begin
        res_done_count++;
        if (res_done_cycle < 0) begin
          res_done_cycle = c;
          res_obs  = observed;
          res_pass = pass;
          res_mm   = mismatch;
`ifdef SWEEP_STOP_ON_FAIL_EN
          res_fail = fail_idx;
`endif
        end
      end else if (res_done_cycle < 0) begin
        if (!busy || row != 3'((c - 1) / rowlen)) res_seq_ok = 1'b0;
      end
      if (res_done_cycle >= 0 && c >= res_done_cycle + tail) break;
      start = (c == pa) || (c == pb);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc_o);
    cyc_o = -1;
    for (int c = 1; c <= limit; c++) begin
      if (done) begin
        cyc_o = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    expected = 8'h00;
    settle   = 8'd0;
    model_tt = 8'h4A;
    stuck0   = 1'b0;
    inv3     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {in1, in2, in3, busy, done, pass, observed, mismatch}, 32'h0);
`ifdef SWEEP_STOP_ON_FAIL_EN
    chk("reset_fail_idx", fail_idx, 3'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ideal gate, with stray start pulses while busy and in DONE.
    sweep(8'h4A, 8'd3, 20, 41, 20);
    chk("ideal_done_cycle", res_done_cycle, 41);
    chk("ideal_done_count", res_done_count, 1);
    chk("ideal_row_seq", res_seq_ok, 1'b1);
    chk("ideal_observed", res_obs, 8'h4A);
    chk("ideal_mismatch", res_mm, 8'h00);
    chk("ideal_pass", res_pass, 1'b1);
    chk("ideal_pass_held", pass, 1'b1);
    chk("ideal_idle_outs", {busy, in1, in2, in3}, 4'h0);

    // Stuck-at-0 gate.
    stuck0 = 1'b1;
    sweep(8'h4A, 8'd3, -1, -1, 2);
    stuck0 = 1'b0;
    chk("stuck_done_cycle", res_done_cycle, 41);
    chk("stuck_observed", res_obs, 8'h00);
    chk("stuck_mismatch", res_mm, 8'h4A);
    chk("stuck_pass", res_pass, 1'b0);

    // Settle clamping.
    sweep(8'h4A, 8'd0, -1, -1, 2);
    chk("settle0_done_cycle", res_done_cycle, 33);
    chk("settle0_row_seq", res_seq_ok, 1'b1);
    chk("settle0_observed", res_obs, 8'h4A);
    chk("settle0_pass", res_pass, 1'b1);
    sweep(8'h4A, 8'd1, -1, -1, 2);
    chk("settle1_done_cycle", res_done_cycle, 33);
    chk("settle1_pass", res_pass, 1'b1);

    // Maximum settle count.
    sweep(8'h4A, 8'hFF, -1, -1, 2);
    chk("settle255_done_cycle", res_done_cycle, 2057);
    chk("settle255_pass", res_pass, 1'b1);

    // Row 3 inverted.
    inv3 = 1'b1;
    sweep(8'h4A, 8'd3, -1, -1, 2);
    inv3 = 1'b0;
`ifdef SWEEP_STOP_ON_FAIL_EN
    chk("inv3_done_cycle", res_done_cycle, 21);
    chk("inv3_observed", res_obs, 8'h50);
    chk("inv3_fail_idx", res_fail, 3'd3);
`else
    chk("inv3_done_cycle", res_done_cycle, 41);
    chk("inv3_observed", res_obs, 8'h5A);
`endif
    chk("inv3_mismatch", res_mm, 8'h10);
    chk("inv3_pass", res_pass, 1'b0);

    // Start held high: next sweep is accepted in the cycle after DONE.
    expected = 8'h4A;
    settle   = 8'd0;
    start    = 1'b1;
    @(posedge clk); #1;
    wait_done(40, cyc);
    chk("hold_first_done", cyc, 33);
    @(posedge clk); #1;
    chk("hold_idle_gap_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("hold_restart_busy", busy, 1'b1);
    start = 1'b0;
    wait_done(40, cyc);
    chk("hold_second_done", cyc, 33);
    chk("hold_second_pass", pass, 1'b1);
    @(posedge clk); #1;

    // Reset in cycle 10 of a sweep.
    model_tt = 8'hFF;
    expected = 8'hFF;
    settle   = 8'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst_pre_observed", observed, 8'h80);
    chk("midrst_pre_row", {busy, row}, 4'b1001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outs", {in1, in2, in3, busy, done, pass, observed, mismatch}, 32'h0);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 45; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", ndone, 0);
    model_tt = 8'h4A;
    sweep(8'h4A, 8'd3, -1, -1, 2);
    chk("postrst_done_cycle", res_done_cycle, 41);
    chk("postrst_observed", res_obs, 8'h4A);
    chk("postrst_pass", res_pass, 1'b1);

    // Reset wins over start in the same cycle.
    start = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_priority_busy", busy, 1'b0);
    chk("rst_priority_pass", pass, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_priority_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
